keypoint_reader: RTL

//  Read-side counterpart of the keypoint writer. Once detection/filtering finishes, drains

---
 rtl/kp_pkg.sv | 38 +++
 rtl/kp_out_fifo.sv | 72 +++++++
 rtl/keypoint_reader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/kp_pkg.sv
// Shared definitions for the keypoint reader.
// This file holds the field widths, the FSM state type, the output entry struct, and a helper
// that splits a raw SRAM word into its row and col fields.
package kp_pkg;

  localparam int unsigned ADDR_W = 11;  // 2K entries per layer
  localparam int unsigned ROW_W  = 9;   // din[18:10]
  localparam int unsigned COL_W  = 10;  // din[9:0]
  localparam int unsigned DATA_W = ROW_W + COL_W;
  localparam int unsigned FIFO_D = 4;

  typedef enum logic [2:0] {
    StIdle,
    StRd1,
    StRd2,
    StDrain,
    StFin
  } kp_state_e;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             layer;
    logic             last;
  } kp_entry_t;

  function automatic kp_entry_t make_entry(input logic [DATA_W-1:0] dout,
                                           input logic              layer,
                                           input logic              last);
    kp_entry_t e;
    e.row   = dout[DATA_W-1:COL_W];
    e.col   = dout[COL_W-1:0];
    e.layer = layer;
    e.last  = last;
    return e;
  endfunction

endpackage

// File: rtl/kp_out_fifo.sv
// Synchronous FIFO of kp_entry_t. The head comes straight from the storage registers, so
// there is no combinational path from push_data_i to head_o.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset (pointers and count only)
//   push_i           write push_data_i at the tail
//   push_data_i      entry to write
//   pop_i            drop the head; ignored when empty
//   head_o           oldest entry; valid only when !empty_o
//   empty_o, full_o  status flags
//   count_o          number of entries held
module kp_out_fifo
  import kp_pkg::*;
#(
  parameter  int unsigned Depth = 4,
  localparam int unsigned PtrW  = $clog2(Depth),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  kp_entry_t       push_data_i,
  input  logic            pop_i,
  output kp_entry_t       head_o,
  output logic            empty_o,
  output logic            full_o,
  output logic [CntW-1:0] count_o
);

  kp_entry_t       mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;

  // Depth is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_i && !do_pop) count_d = count_q + CntW'(1);
    if (!push_i && do_pop) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The storage needs no reset. Stale contents are hidden behind empty_o.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // The issue credit upstream must never let a push land on a full FIFO.
  assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));

endmodule

// File: rtl/keypoint_reader.sv
// Drains keypoint SRAM 1 (layer 0) and then SRAM 2 (layer 1) onto a valid/ready stream.
// The first read issues in the start cycle itself. That keeps start-to-first-kp_valid at
// 2 cycles, even with the SRAM latency and the registered FIFO head in the path.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, count_1, count_2       begin a readout; the counts are latched on start
//   keypoint_{1,2}_addr/_dout     SRAM read ports (dout valid 1 cycle after addr)
//   kp_valid/kp_ready             output handshake
//   kp_row/col/layer/last         output entry (0 while !kp_valid)
//   busy, done                    readout in progress / 1-cycle end pulse
module keypoint_reader
  import kp_pkg::*;
#(
  parameter int unsigned FIFO_D = kp_pkg::FIFO_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] count_1,
  input  logic [ADDR_W-1:0] count_2,
  output logic [ADDR_W-1:0] keypoint_1_addr,
  input  logic [DATA_W-1:0] keypoint_1_dout,
  output logic [ADDR_W-1:0] keypoint_2_addr,
  input  logic [DATA_W-1:0] keypoint_2_dout,
  output logic              kp_valid,
  input  logic              kp_ready,
  output logic [ROW_W-1:0]  kp_row,
  output logic [COL_W-1:0]  kp_col,
  output logic              kp_layer,
  output logic              kp_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW = $clog2(FIFO_D) + 1;

  kp_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic              inflight_q, inflight_d;
  logic              inf_layer_q, inf_layer_d;
  logic              inf_last_q, inf_last_d;

  logic              rd_active, rd_layer, rd_issue, rd_end, rd_last, credit_ok;
  logic [ADDR_W-1:0] rd_addr, rd_cnt, rd_cnt2;

  logic              fifo_pop, fifo_empty, fifo_full;
  logic [CntW-1:0]   fifo_count;
  kp_entry_t         push_entry, head, out_entry;

  // A pop in the same cycle is not credited. This keeps the issue path off kp_ready.
  assign credit_ok = !fifo_full && ((int'(fifo_count) + int'(inflight_q)) < int'(FIFO_D));

  // The issue side is viewed as a single read port. In the start cycle, the counts come
  // straight from the inputs, because the latched copies are not loaded yet.
  always_comb begin
    rd_active = 1'b0;
    rd_layer  = 1'b0;
    rd_addr   = '0;
    rd_cnt    = '0;
    rd_cnt2   = cnt2_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          rd_active = (count_1 != '0) || (count_2 != '0);
          rd_layer  = (count_1 == '0);
          rd_cnt    = (count_1 == '0) ? count_2 : count_1;
          rd_cnt2   = count_2;
        end
      end
      StRd1: begin
        rd_active = 1'b1;
        rd_addr   = addr1_q;
        rd_cnt    = cnt1_q;
      end
      StRd2: begin
        rd_active = 1'b1;
        rd_layer  = 1'b1;
        rd_addr   = addr2_q;
        rd_cnt    = cnt2_q;
      end
      default: ;
    endcase
    rd_issue = rd_active && credit_ok;
    rd_end   = (rd_addr == rd_cnt - ADDR_W'(1));
    rd_last  = rd_end && (rd_layer || (rd_cnt2 == '0));
  end

  always_comb begin
    state_d     = state_q;
    cnt1_d      = cnt1_q;
    cnt2_d      = cnt2_q;
    addr1_d     = addr1_q;
    addr2_d     = addr2_q;
    inflight_d  = rd_issue;
    inf_layer_d = rd_layer;
    inf_last_d  = rd_last;

    case (state_q)
      StIdle: begin
        if (start) begin
          cnt1_d = count_1;
          cnt2_d = count_2;
          if (count_1 != '0)      state_d = StRd1;
          else if (count_2 != '0) state_d = StRd2;
          else                    state_d = StDrain;
        end
      end
      StDrain: begin
        // Leave on the final handshake itself, so done lands in the very next cycle.
        if ((!inflight_q && fifo_empty) || (fifo_pop && head.last)) state_d = StFin;
      end
      StFin: begin
        state_d = StIdle;
        addr1_d = '0;
        addr2_d = '0;
      end
      default: ;
    endcase

    // The address advances only on an issue and stops at count-1.
    if (rd_issue) begin
      if (rd_end) begin
        state_d = (!rd_layer && (rd_cnt2 != '0)) ? StRd2 : StDrain;
      end else if (rd_layer) begin
        addr2_d = rd_addr + ADDR_W'(1);
      end else begin
        addr1_d = rd_addr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt1_q      <= '0;
      cnt2_q      <= '0;
      addr1_q     <= '0;
      addr2_q     <= '0;
      inflight_q  <= 1'b0;
      inf_layer_q <= 1'b0;
      inf_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt1_q      <= cnt1_d;
      cnt2_q      <= cnt2_d;
      addr1_q     <= addr1_d;
      addr2_q     <= addr2_d;
      inflight_q  <= inflight_d;
      inf_layer_q <= inf_layer_d;
      inf_last_q  <= inf_last_d;
    end
  end

  assign push_entry = make_entry(inf_layer_q ? keypoint_2_dout : keypoint_1_dout,
                                 inf_layer_q, inf_last_q);
  assign fifo_pop   = kp_valid && kp_ready;

  kp_out_fifo #(
    .Depth(FIFO_D)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (inflight_q),
    .push_data_i(push_entry),
    .pop_i      (fifo_pop),
    .head_o     (head),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .count_o    (fifo_count)
  );

  assign keypoint_1_addr = addr1_q;
  assign keypoint_2_addr = addr2_q;
  assign kp_valid        = !fifo_empty;
  assign out_entry       = fifo_empty ? '0 : head;
  assign kp_row          = out_entry.row;
  assign kp_col          = out_entry.col;
  assign kp_layer        = out_entry.layer;
  assign kp_last         = out_entry.last;
  assign busy            = (state_q == StRd1) || (state_q == StRd2) || (state_q == StDrain);
  assign done            = (state_q == StFin);

endmodule
